// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encodings for the decoder stage controller and the Union-Find PE array.
// PEs decode these same constants, so every consumer imports this package.
package decoder_stage_controller_pkg;

    localparam int unsigned STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_MEASUREMENT_LOADING = 3'd1,
        STAGE_GROW                = 3'd2,
        STAGE_MERGE               = 3'd3,
        STAGE_PEELING             = 3'd4,
        STAGE_RESULT_VALID        = 3'd5
    } stage_e;

endpackage

// File: rtl/decoder_stage_controller.sv
// Sequences global_stage load -> grow -> merge -> peel for one decode round.
// Optional iteration limit enabled by the STAGE_TIMEOUT_EN macro.
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int unsigned PE_LATENCY     = 3,
    parameter int unsigned ITER_WIDTH     = 8,
    parameter int unsigned MAX_ITERATIONS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   measurement_valid,
    output logic                   measurement_ready,
    input  logic                   busy_any,
    input  logic                   odd_any,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout_error
);

    localparam int unsigned WAIT_WIDTH = (PE_LATENCY < 1) ? 1 : $clog2(PE_LATENCY + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD  = WAIT_WIDTH'(PE_LATENCY);
    localparam logic [ITER_WIDTH-1:0] ITER_SAT   = '1;
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_ITERATIONS);
`ifdef STAGE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    stage_e                  state_q, state_d;
    logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
    logic [ITER_WIDTH-1:0]   iter_d;
    logic                    timeout_d;
    logic                    busy_q, odd_q;

    // The stage register is broadcast directly to the PE array.
    assign global_stage = state_q;

    // Next-state, merge wait counter, iteration counter and timeout flag.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        iter_d    = iteration_count;
        timeout_d = timeout_error;
        case (state_q)
            STAGE_IDLE: begin
                if (measurement_valid && measurement_ready) begin
                    state_d   = STAGE_MEASUREMENT_LOADING;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            STAGE_MEASUREMENT_LOADING: state_d = STAGE_GROW;
            STAGE_GROW: begin
                state_d = STAGE_MERGE;
                wait_d  = WAIT_LOAD;
                if (iteration_count != ITER_SAT) begin
                    iter_d = iteration_count + ITER_WIDTH'(1);
                end
            end
            STAGE_MERGE: begin
                // busy_q/odd_q still describe the previous stage until the wait expires.
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_WIDTH'(1);
                end else if (!busy_q) begin
                    if (!odd_q) begin
                        state_d = STAGE_PEELING;
                    end else if (TIMEOUT_EN && (iteration_count >= ITER_LIMIT)) begin
                        state_d   = STAGE_PEELING;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = STAGE_GROW;
                    end
                end
            end
            STAGE_PEELING: state_d = STAGE_RESULT_VALID;
            STAGE_RESULT_VALID: begin
                if (result_ack) begin
                    state_d = STAGE_IDLE;
                end
            end
            default: state_d = STAGE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= STAGE_IDLE;
            wait_q            <= '0;
            iteration_count   <= '0;
            timeout_error     <= 1'b0;
            busy_q            <= 1'b0;
            odd_q             <= 1'b0;
            measurement_ready <= 1'b1;
            result_valid      <= 1'b0;
        end else begin
            state_q           <= state_d;
            wait_q            <= wait_d;
            iteration_count   <= iter_d;
            timeout_error     <= timeout_d;
            busy_q            <= busy_any;
            odd_q             <= odd_any;
            measurement_ready <= (state_d == STAGE_IDLE);
            result_valid      <= (state_d == STAGE_RESULT_VALID);
        end
    end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench for decoder_stage_controller: expected stage sequences are queued
// per round and popped as the DUT steps; a stub array model drives busy_any/odd_any.
module tb_decoder_stage_controller;
    import decoder_stage_controller_pkg::*;

    localparam int unsigned PE_LAT = 3;
    localparam int unsigned ITER_W = 8;
    localparam int unsigned MAX_IT = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   measurement_valid = 1'b0;
    logic                   measurement_ready;
    logic                   busy_any = 1'b0;
    logic                   odd_any = 1'b0;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic                   result_valid;
    logic                   result_ack = 1'b0;
    logic [ITER_W-1:0]      iteration_count;
    logic                   timeout_error;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected global_stage values, one per cycle.
    logic [STAGE_WIDTH-1:0] sb[$];

    // Stub array: busy_any high for merge-relative cycles busy_lo..busy_hi (0 = the GROW
    // cycle, 1 = first MERGE cycle); odd_any high while at most odd_grows GROWs have run.
    int busy_lo = 1, busy_hi = 0, odd_grows = 0;
    int merge_k = -1, grow_seen = 0;

    decoder_stage_controller #(
        .PE_LATENCY(PE_LAT), .ITER_WIDTH(ITER_W), .MAX_ITERATIONS(MAX_IT)
    ) dut (
        .clk(clk), .reset(reset),
        .measurement_valid(measurement_valid), .measurement_ready(measurement_ready),
        .busy_any(busy_any), .odd_any(odd_any), .global_stage(global_stage),
        .result_valid(result_valid), .result_ack(result_ack),
        .iteration_count(iteration_count), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    // Advance to the next negedge, sample the stage and update the stub array outputs.
    task automatic cycle(output logic [STAGE_WIDTH-1:0] obs);
        @(negedge clk);
        obs = global_stage;
        if (obs == STAGE_GROW) begin
            merge_k = 0;
            grow_seen++;
        end else if (obs == STAGE_MERGE) begin
            merge_k++;
        end else begin
            merge_k = -1;
            if (obs == STAGE_IDLE || obs == STAGE_MEASUREMENT_LOADING) grow_seen = 0;
        end
        busy_any = (merge_k >= busy_lo) && (merge_k <= busy_hi);
        odd_any  = (merge_k >= 0) && (grow_seen <= odd_grows);
    endtask

    function automatic void push_round(input int grows, input int merge_len, input bit with_result);
        sb.push_back(STAGE_MEASUREMENT_LOADING);
        for (int g = 0; g < grows; g++) begin
            sb.push_back(STAGE_GROW);
            for (int m = 0; m < merge_len; m++) sb.push_back(STAGE_MERGE);
        end
        sb.push_back(STAGE_PEELING);
        if (with_result) sb.push_back(STAGE_RESULT_VALID);
    endfunction

    task automatic test_reset();
        logic [STAGE_WIDTH-1:0] obs;
        reset = 1'b1;
        cycle(obs);
        cycle(obs);
        checks++;
        if (obs !== STAGE_IDLE || measurement_ready !== 1'b1 || result_valid !== 1'b0 ||
            iteration_count !== 8'd0 || timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL reset: stage=%0d ready=%0b valid=%0b iter=%0d tmo=%0b, want 0 1 0 0 0",
                     obs, measurement_ready, result_valid, iteration_count, timeout_error);
        end
        reset = 1'b0;
        cycle(obs);
    endtask

    task automatic test_no_defects();
        logic [STAGE_WIDTH-1:0] obs, exp;
        busy_lo = 1; busy_hi = 0; odd_grows = 0;
        push_round(1, PE_LAT + 1, 1'b1);
        measurement_valid = 1'b1;
        while (sb.size() != 0) begin
            cycle(obs);
            measurement_valid = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL no_defects stage: got %0d want %0d", obs, exp);
            end
        end
        checks++;
        if (iteration_count !== 8'd1 || result_valid !== 1'b1 || measurement_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_defects result: iter=%0d valid=%0b ready=%0b, want 1 1 0",
                     iteration_count, result_valid, measurement_ready);
        end
        result_ack = 1'b1;
        cycle(obs);
        result_ack = 1'b0;
        checks++;
        if (obs !== STAGE_IDLE || measurement_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_defects ack: stage=%0d ready=%0b valid=%0b, want 0 1 0",
                     obs, measurement_ready, result_valid);
        end
    endtask

    task automatic test_stub_array();
        logic [STAGE_WIDTH-1:0] obs, exp;
        // busy_any high in MERGE cycles 1..5 -> busy_q high in 2..6 -> exit in cycle 7.
        busy_lo = 1; busy_hi = 5; odd_grows = 2;
        push_round(3, 7, 1'b1);
        measurement_valid = 1'b1;
        while (sb.size() != 0) begin
            cycle(obs);
            measurement_valid = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stub_array stage: got %0d want %0d", obs, exp);
            end
        end
        checks++;
        if (iteration_count !== 8'd3) begin
            errors++;
            $display("FAIL stub_array iter: got %0d want 3", iteration_count);
        end
        result_ack = 1'b1;
        cycle(obs);
        result_ack = 1'b0;
        busy_lo = 1; busy_hi = 0; odd_grows = 0;
    endtask

    task automatic test_busy_masked();
        logic [STAGE_WIDTH-1:0] obs, exp;
        for (int pass = 0; pass < 2; pass++) begin
            // Pass 0: busy lands in busy_q only while the wait counter runs -> MERGE lasts 4.
            // Pass 1: busy in MERGE cycle 3 is seen in cycle 4 -> MERGE lasts 5.
            busy_lo = (pass == 0) ? 0 : 3;
            busy_hi = (pass == 0) ? 2 : 3;
            odd_grows = 0;
            push_round(1, (pass == 0) ? PE_LAT + 1 : PE_LAT + 2, 1'b1);
            measurement_valid = 1'b1;
            while (sb.size() != 0) begin
                cycle(obs);
                measurement_valid = 1'b0;
                exp = sb.pop_front();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL busy_masked pass%0d stage: got %0d want %0d", pass, obs, exp);
                end
            end
            result_ack = 1'b1;
            cycle(obs);
            result_ack = 1'b0;
        end
        busy_lo = 1; busy_hi = 0;
    endtask

    task automatic test_hold_result();
        logic [STAGE_WIDTH-1:0] obs;
        busy_lo = 1; busy_hi = 0; odd_grows = 0;
        measurement_valid = 1'b1;
        for (int n = 0; n < 20 && obs !== STAGE_RESULT_VALID; n++) begin
            cycle(obs);
            measurement_valid = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            measurement_valid = (i % 2 == 0);
            cycle(obs);
            checks++;
            if (obs !== STAGE_RESULT_VALID || result_valid !== 1'b1 || measurement_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_result cycle%0d: stage=%0d valid=%0b ready=%0b, want 5 1 0",
                         i, obs, result_valid, measurement_ready);
            end
        end
        measurement_valid = 1'b0;
        result_ack = 1'b1;
        cycle(obs);
        result_ack = 1'b0;
        checks++;
        if (obs !== STAGE_IDLE || measurement_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_result ack: stage=%0d ready=%0b valid=%0b, want 0 1 0",
                     obs, measurement_ready, result_valid);
        end
        cycle(obs);
        checks++;
        if (obs !== STAGE_IDLE) begin
            errors++;
            $display("FAIL hold_result not_queued: stage=%0d want 0", obs);
        end
    endtask

    task automatic test_ack_at_entry();
        logic [STAGE_WIDTH-1:0] obs, exp;
        busy_lo = 1; busy_hi = 0; odd_grows = 0;
        push_round(1, PE_LAT + 1, 1'b0);
        measurement_valid = 1'b1;
        while (sb.size() != 0) begin
            cycle(obs);
            measurement_valid = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ack_at_entry stage: got %0d want %0d", obs, exp);
            end
        end
        // Ack raised in PEELING is ignored there and honoured on the RESULT_VALID entry cycle.
        result_ack = 1'b1;
        cycle(obs);
        checks++;
        if (obs !== STAGE_RESULT_VALID || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_entry result: stage=%0d valid=%0b, want 5 1", obs, result_valid);
        end
        cycle(obs);
        result_ack = 1'b0;
        checks++;
        if (obs !== STAGE_IDLE || result_valid !== 1'b0 || measurement_ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_entry idle: stage=%0d valid=%0b ready=%0b, want 0 0 1",
                     obs, result_valid, measurement_ready);
        end
    endtask

    task automatic test_reset_mid_merge();
        logic [STAGE_WIDTH-1:0] obs;
        busy_lo = 1; busy_hi = 0; odd_grows = 1000;
        measurement_valid = 1'b1;
        for (int n = 0; n < 10 && obs !== STAGE_MERGE; n++) begin
            cycle(obs);
            measurement_valid = 1'b0;
        end
        checks++;
        if (obs !== STAGE_MERGE) begin
            errors++;
            $display("FAIL reset_mid_merge reach: stage=%0d want 3", obs);
        end
        reset = 1'b1;
        cycle(obs);
        reset = 1'b0;
        checks++;
        if (obs !== STAGE_IDLE || result_valid !== 1'b0 || iteration_count !== 8'd0 ||
            measurement_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_merge: stage=%0d valid=%0b iter=%0d ready=%0b, want 0 0 0 1",
                     obs, result_valid, iteration_count, measurement_ready);
        end
        odd_grows = 0;
        cycle(obs);
        checks++;
        if (obs !== STAGE_IDLE || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_merge after: stage=%0d valid=%0b, want 0 0", obs, result_valid);
        end
    endtask

    task automatic test_timeout();
        logic [STAGE_WIDTH-1:0] obs, exp;
        busy_lo = 1; busy_hi = 0; odd_grows = 1000;
`ifdef STAGE_TIMEOUT_EN
        push_round(MAX_IT, PE_LAT + 1, 1'b1);
`else
        sb.push_back(STAGE_MEASUREMENT_LOADING);
        for (int g = 0; g < 6; g++) begin
            sb.push_back(STAGE_GROW);
            for (int m = 0; m < PE_LAT + 1; m++) sb.push_back(STAGE_MERGE);
        end
`endif
        measurement_valid = 1'b1;
        while (sb.size() != 0) begin
            cycle(obs);
            measurement_valid = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout stage: got %0d want %0d", obs, exp);
            end
        end
`ifdef STAGE_TIMEOUT_EN
        checks++;
        if (timeout_error !== 1'b1 || iteration_count !== 8'd4 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout flag: tmo=%0b iter=%0d valid=%0b, want 1 4 1",
                     timeout_error, iteration_count, result_valid);
        end
        odd_grows = 0;
`else
        checks++;
        if (timeout_error !== 1'b0 || iteration_count !== 8'd6) begin
            errors++;
            $display("FAIL timeout unbounded: tmo=%0b iter=%0d, want 0 6", timeout_error, iteration_count);
        end
        odd_grows = 0;
        for (int n = 0; n < 30 && obs !== STAGE_RESULT_VALID; n++) cycle(obs);
        checks++;
        if (obs !== STAGE_RESULT_VALID || timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout drain: stage=%0d tmo=%0b, want 5 0", obs, timeout_error);
        end
`endif
        result_ack = 1'b1;
        cycle(obs);
        result_ack = 1'b0;
`ifdef STAGE_TIMEOUT_EN
        checks++;
        if (obs !== STAGE_IDLE || timeout_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout hold: stage=%0d tmo=%0b, want 0 1", obs, timeout_error);
        end
        measurement_valid = 1'b1;
        cycle(obs);
        measurement_valid = 1'b0;
        checks++;
        if (timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout clear: tmo=%0b want 0", timeout_error);
        end
        for (int n = 0; n < 30 && obs !== STAGE_RESULT_VALID; n++) cycle(obs);
        result_ack = 1'b1;
        cycle(obs);
        result_ack = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_no_defects();
        test_stub_array();
        test_busy_masked();
        test_hold_result();
        test_ack_at_entry();
        test_reset_mid_merge();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
